u_imem: RTL and testbench



---
 rtl/u_imem.sv | 213 +++++++++++++++++++++
 tb/tb_u_imem.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_imem.sv
// ----------------------------------------------------------------------------
// u_imem -- instruction memory responder with a byte-stream program loader.
//
// The fetch side answers the core's address/enable with a registered 32-bit
// word (one-cycle latency). The loader side assembles little-endian bytes into
// words and writes them into the array. While a load is in progress the core
// is stalled through cpu_hold.
//
// Ports:
//   clk        single clock, all logic on posedge
//   rst        synchronous, active-high reset (does not clear the array)
//   ins_a      fetch byte address; word index is ins_a[15:2]
//   ins_e      fetch enable
//   ins        registered instruction word
//   misalign   registered flag: last accepted fetch had ins_a[1:0] != 0
//   ld_start   single-cycle pulse starting a load (honoured only when idle)
//   ld_base    byte base address of the load; bits [1:0] ignored
//   ld_nwords  number of words to load
//   ld_valid   byte stream valid
//   ld_byte    byte stream data, little-endian within each word
//   ld_ready   loader accepts a byte
//   ld_busy    load in progress
//   cpu_hold   core stall request, equal to ld_busy
//   ld_done    one-cycle completion pulse
//   ld_err     sticky: a word of the current/last load fell outside the array
// ----------------------------------------------------------------------------
module u_imem #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ins_a,
    input  logic        ins_e,
    output logic [31:0] ins,
    output logic        misalign,
    input  logic        ld_start,
    input  logic [15:0] ld_base,
    input  logic [15:0] ld_nwords,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        cpu_hold,
    output logic        ld_done,
    output logic        ld_err
);

    localparam int unsigned AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [15:0] DEPTH = 16'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t state, state_next;

    logic [31:0] mem [0:MEM_WORDS-1];

    logic [14:0] ptr, ptr_next;
    logic [15:0] rem, rem_next;
    logic [1:0]  byte_cnt, byte_cnt_next;
    logic [23:0] partial, partial_next;
    logic        err, err_next;

    logic          accept;
    logic          ptr_in_range;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic [AW-1:0] wr_addr;

    logic [13:0]   rd_idx;
    logic          rd_in_range;

    // Low address bits of the load base carry no meaning for word loads.
    logic unused_base_bits;
    assign unused_base_bits = &{1'b0, ld_base[1:0]};

    assign accept       = (state == LOAD) && ld_valid;
    assign ptr_in_range = ({1'b0, ptr} < DEPTH);
    assign wr_addr      = ptr[AW-1:0];
    assign wr_data      = {ld_byte, partial};

    assign rd_idx       = ins_a[15:2];
    assign rd_in_range  = ({2'b00, rd_idx} < DEPTH);

    assign cpu_hold     = ld_busy;
    assign ld_err       = err;

    // ------------------------------------------------------------------
    // Loader FSM: state register and loader datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            rem      <= '0;
            byte_cnt <= '0;
            partial  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            rem      <= rem_next;
            byte_cnt <= byte_cnt_next;
            partial  <= partial_next;
            err      <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM: next state, datapath updates and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        rem_next      = rem;
        byte_cnt_next = byte_cnt;
        partial_next  = partial;
        err_next      = err;
        wr_en         = 1'b0;
        ld_ready      = 1'b0;
        ld_busy       = 1'b0;
        ld_done       = 1'b0;

        case (state)
            IDLE: begin
                if (ld_start) begin
                    ptr_next      = {1'b0, ld_base[15:2]};
                    rem_next      = ld_nwords;
                    byte_cnt_next = '0;
                    err_next      = 1'b0;
                    state_next    = (ld_nwords != 16'd0) ? LOAD : DONE;
                end
            end

            LOAD: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (accept) begin
                    case (byte_cnt)
                        2'd0: begin
                            partial_next[7:0] = ld_byte;
                            byte_cnt_next     = 2'd1;
                        end
                        2'd1: begin
                            partial_next[15:8] = ld_byte;
                            byte_cnt_next      = 2'd2;
                        end
                        2'd2: begin
                            partial_next[23:16] = ld_byte;
                            byte_cnt_next       = 2'd3;
                        end
                        default: begin
                            if (ptr_in_range) begin
                                wr_en = 1'b1;
                            end else begin
                                err_next = 1'b1;
                            end
                            // Saturate rather than wrap so a long load that
                            // runs past the array never lands back inside it.
                            ptr_next      = (ptr == '1) ? ptr : ptr + 15'd1;
                            rem_next      = rem - 16'd1;
                            byte_cnt_next = '0;
                            if (rem == 16'd1) begin
                                state_next = DONE;
                            end
                        end
                    endcase
                end
            end

            DONE: begin
                ld_done    = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Array write port. Not reset; reset on the same edge blocks the write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch read port, one-cycle latency. Any fetch while the loader is
    // active returns NOP_WORD so the core never executes a half-loaded image.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ins      <= '0;
            misalign <= 1'b0;
        end else if (ins_e) begin
            misalign <= (ins_a[1:0] != 2'b00);
            if ((state != IDLE) || !rd_in_range) begin
                ins <= NOP_WORD;
            end else begin
                ins <= mem[rd_idx[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_u_imem.sv
module tb_u_imem;

    localparam int unsigned MW  = 4096;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ins_a = '0;
    logic        ins_e = 1'b0;
    logic [31:0] ins;
    logic        misalign;
    logic        ld_start = 1'b0;
    logic [15:0] ld_base = '0;
    logic [15:0] ld_nwords = '0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_ready;
    logic        ld_busy;
    logic        cpu_hold;
    logic        ld_done;
    logic        ld_err;

    int checks = 0;
    int errors = 0;

    // Reference model: word array, which entries are known, and sticky error
    logic [31:0] model_mem [MW];
    bit          model_known [MW];
    bit          model_err;
    logic [31:0] wq [$];

    u_imem #(
        .MEM_WORDS(MW),
        .NOP_WORD (NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ins_a    (ins_a),
        .ins_e    (ins_e),
        .ins      (ins),
        .misalign (misalign),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_nwords(ld_nwords),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .ld_ready (ld_ready),
        .ld_busy  (ld_busy),
        .cpu_hold (cpu_hold),
        .ld_done  (ld_done),
        .ld_err   (ld_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of a whole load: word i goes to (base/4)+i, if it fits.
    task automatic model_load(input logic [15:0] base);
        int unsigned idx;
        model_err = 0;
        foreach (wq[i]) begin
            idx = int'(base >> 2) + i;
            if (idx < MW) begin
                model_mem[idx]   = wq[i];
                model_known[idx] = 1;
            end else begin
                model_err = 1;
            end
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [15:0] a);
        int unsigned idx;
        idx = int'(a >> 2);
        if (idx >= MW) return NOP;
        return model_mem[idx];
    endfunction

    task automatic start_load(input logic [15:0] base, input logic [15:0] n);
        ld_start  = 1'b1;
        ld_base   = base;
        ld_nwords = n;
        tick();
        ld_start  = 1'b0;
    endtask

    // One stream cycle in LOAD: observe the handshake flags, issue a fetch
    // that must come back as NOP.
    task automatic stream_cycle(inout int flag_bad, inout int nop_bad);
        if (!(ld_ready === 1'b1 && ld_busy === 1'b1 && cpu_hold === 1'b1)) flag_bad++;
        ins_a = 16'($urandom_range(0, 16'h3FFF));
        ins_e = 1'b1;
        tick();
        if (ins !== NOP) nop_bad++;
    endtask

    task automatic send_stream(input int max_gap, output int flag_bad, output int nop_bad);
        logic [31:0] wv;
        int gaps;
        flag_bad = 0;
        nop_bad  = 0;
        foreach (wq[w]) begin
            wv = wq[w];
            for (int b = 0; b < 4; b++) begin
                gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
                for (int g = 0; g < gaps; g++) begin
                    ld_valid = 1'b0;
                    stream_cycle(flag_bad, nop_bad);
                end
                ld_valid = 1'b1;
                ld_byte  = wv[8*b +: 8];
                stream_cycle(flag_bad, nop_bad);
            end
        end
        ld_valid = 1'b0;
        ins_e    = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [31:0] d, output logic m);
        ins_a = a;
        ins_e = 1'b1;
        tick();
        d = ins;
        m = misalign;
        ins_e = 1'b0;
    endtask

    // Full load with completion-pulse checks
    task automatic run_load(input string tag, input logic [15:0] base, input int max_gap);
        int fb, nb;
        start_load(base, 16'(wq.size()));
        model_load(base);
        send_stream(max_gap, fb, nb);
        checks++;
        if (fb !== 0) begin
            errors++;
            $display("FAIL %s busy/hold/ready: %0d cycles low, expected 0", tag, fb);
        end
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL %s nop-during-load: %0d non-NOP reads, expected 0", tag, nb);
        end
        checks++;
        if ({ld_done, ld_busy, ld_ready} !== 3'b100) begin
            errors++;
            $display("FAIL %s done-pulse: done/busy/ready=%b expected 100", tag, {ld_done, ld_busy, ld_ready});
        end
        tick();
        checks++;
        if ({ld_done, ld_busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s done-end: done/busy=%b expected 00", tag, {ld_done, ld_busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (ins !== 32'h0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset-read: ins=%h misalign=%b expected 00000000/0", ins, misalign);
        end
        checks++;
        if ({ld_ready, ld_busy, cpu_hold, ld_done, ld_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset-loader: ready/busy/hold/done/err=%b expected 00000",
                     {ld_ready, ld_busy, cpu_hold, ld_done, ld_err});
        end
    endtask

    task automatic test_basic_load();
        logic [31:0] d;
        logic m;
        wq = '{32'h0000_0013, 32'h0010_0093};
        run_load("basic", 16'h0000, 0);
        do_read(16'h0000, d, m);
        checks++;
        if (d !== 32'h0000_0013) begin
            errors++;
            $display("FAIL basic-read0: ins=%h expected 00000013", d);
        end
        do_read(16'h0004, d, m);
        checks++;
        if (d !== 32'h0010_0093) begin
            errors++;
            $display("FAIL basic-read4: ins=%h expected 00100093", d);
        end
    endtask

    task automatic test_gapped_load();
        logic [31:0] d;
        logic m;
        // Scramble the two words first so the gapped load must rewrite them.
        wq = '{$urandom, $urandom};
        run_load("scramble", 16'h0000, 0);
        do_read(16'h0000, d, m);
        checks++;
        if (d !== exp_word(16'h0000)) begin
            errors++;
            $display("FAIL scramble-read0: ins=%h expected %h", d, exp_word(16'h0000));
        end
        wq = '{32'h0000_0013, 32'h0010_0093};
        run_load("gapped", 16'h0000, 3);
        for (int i = 0; i < 2; i++) begin
            do_read(16'(4 * i), d, m);
            checks++;
            if (d !== wq[i]) begin
                errors++;
                $display("FAIL gapped-read%0d: ins=%h expected %h", i, d, wq[i]);
            end
        end
    endtask

    task automatic test_read_edges();
        logic [31:0] d, held;
        logic m, mheld;
        do_read(16'h4000, d, m);
        checks++;
        if (d !== NOP || m !== 1'b0) begin
            errors++;
            $display("FAIL oor-read: ins=%h misalign=%b expected %h/0", d, m, NOP);
        end
        do_read(16'h0006, d, m);
        checks++;
        if (d !== 32'h0010_0093 || m !== 1'b1) begin
            errors++;
            $display("FAIL misaligned-read: ins=%h misalign=%b expected 00100093/1", d, m);
        end
        held  = d;
        mheld = m;
        for (int i = 0; i < 3; i++) begin
            ins_a = 16'($urandom_range(0, 16'h3FFF)) & 16'hFFFC;
            ins_e = 1'b0;
            tick();
            checks++;
            if (ins !== held || misalign !== mheld) begin
                errors++;
                $display("FAIL hold-disabled%0d: ins=%h misalign=%b expected %h/%b",
                         i, ins, misalign, held, mheld);
            end
        end
    endtask

    task automatic test_zero_words();
        ld_start  = 1'b1;
        ld_base   = 16'h0100;
        ld_nwords = 16'd0;
        tick();
        model_err = 0;
        checks++;
        if ({ld_done, ld_busy, cpu_hold, ld_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL zero-done: done/busy/hold/ready=%b expected 1000",
                     {ld_done, ld_busy, cpu_hold, ld_ready});
        end
        // Start pulse coinciding with ld_done must be ignored.
        ld_start  = 1'b1;
        ld_nwords = 16'd1;
        tick();
        ld_start = 1'b0;
        checks++;
        if ({ld_done, ld_busy, ld_ready} !== 3'b000) begin
            errors++;
            $display("FAIL zero-ignore-start: done/busy/ready=%b expected 000", {ld_done, ld_busy, ld_ready});
        end
        tick();
        checks++;
        if (ld_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero-stay-idle: busy=%b expected 0", ld_busy);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic m;
        wq = '{32'hDDCC_BBAA, 32'h4433_2211};
        run_load("overflow", 16'h3FFC, 0);
        checks++;
        if (ld_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow-err: ld_err=%b expected 1", ld_err);
        end
        do_read(16'h3FFC, d, m);
        checks++;
        if (d !== 32'hDDCC_BBAA) begin
            errors++;
            $display("FAIL overflow-last-word: ins=%h expected ddccbbaa", d);
        end
        tick();
        tick();
        checks++;
        if (ld_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow-sticky: ld_err=%b expected 1", ld_err);
        end
        start_load(16'h0000, 16'd0);
        model_err = 0;
        checks++;
        if (ld_err !== 1'b0) begin
            errors++;
            $display("FAIL overflow-clear: ld_err=%b expected 0", ld_err);
        end
        tick();
    endtask

    task automatic test_random_loads();
        logic [31:0] d;
        logic m;
        logic [15:0] base, a;
        int n;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 2) == 0) base = 16'(16'h3FF0 + $urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) base = 16'($urandom);
            else base = 16'($urandom_range(0, 16'h3FFF));
            n = $urandom_range(1, 5);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            run_load($sformatf("rand%0d", it), base, 2);
            checks++;
            if (ld_err !== model_err) begin
                errors++;
                $display("FAIL rand%0d-err: ld_err=%b expected %b", it, ld_err, model_err);
            end
            for (int i = 0; i < n; i++) begin
                a = 16'({base[15:2], 2'b00} + 4 * i) | 16'($urandom_range(0, 3));
                do_read(a, d, m);
                checks++;
                if (d !== exp_word(a) || m !== (a[1:0] != 2'b00)) begin
                    errors++;
                    $display("FAIL rand%0d-read a=%h: ins=%h misalign=%b expected %h/%b",
                             it, a, d, m, exp_word(a), (a[1:0] != 2'b00));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, prev;
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back($urandom);
        run_load("b2b-load", 16'h0200, 0);
        ins_e = 1'b1;
        prev  = 16'h0200;
        ins_a = prev;
        tick();
        for (int i = 1; i <= 10; i++) begin
            a = (i % 3 == 0) ? 16'(16'h4000 + 4 * i) : 16'(16'h0200 + 4 * (i % 8));
            ins_a = a;
            checks++;
            if (ins !== exp_word(prev)) begin
                errors++;
                $display("FAIL b2b-read%0d a=%h: ins=%h expected %h", i, prev, ins, exp_word(prev));
            end
            prev = a;
            tick();
        end
        ins_e = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] d;
        logic m;
        wq = '{32'h1234_5678};
        run_load("pre-reset", 16'h0010, 0);
        start_load(16'h0010, 16'd1);
        for (int b = 0; b < 3; b++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
            tick();
        end
        // Fourth byte offered on the reset edge: reset must win.
        ld_byte = 8'hEE;
        rst     = 1'b1;
        tick();
        rst      = 1'b0;
        ld_valid = 1'b0;
        model_err = 0;
        checks++;
        if ({ld_ready, ld_busy, cpu_hold, ld_done} !== 4'b0000 || ins !== 32'h0) begin
            errors++;
            $display("FAIL midreset-state: ready/busy/hold/done=%b ins=%h expected 0000/00000000",
                     {ld_ready, ld_busy, cpu_hold, ld_done}, ins);
        end
        do_read(16'h0010, d, m);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL midreset-read: ins=%h expected 12345678", d);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_read_edges();
        test_zero_words();
        test_overflow();
        test_random_loads();
        test_back_to_back();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
